// File: rtl/frame_tx_master_if.sv
// Wishbone pipelined master/slave bundle used by the frame transmitter.
interface frame_tx_master_if #(
  parameter int DATA_W = 8
);
  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [1:0]        o_wb_addr;
  logic [DATA_W-1:0] o_wb_data;
  logic              i_wb_ack;
  logic              i_wb_stall;
  logic [DATA_W-1:0] i_wb_data;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    input  i_wb_ack, i_wb_stall, i_wb_data
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
    output i_wb_ack, i_wb_stall, i_wb_data
  );
endinterface

// File: rtl/frame_tx_master.sv
// Frame transmitter: streams a buffered payload into a MAC-like slave over
// pipelined Wishbone (data bytes, length, send strobe, busy polling), then
// waits an inter-frame gap and optionally repeats the frame.
module frame_tx_master #(
  parameter int DATA_W      = 8,
  parameter int MEM_AW      = 8,
  parameter int CRC_BYTES   = 4,
  parameter int GAP_CYC     = 100,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                buf_we,
  input  logic [MEM_AW-1:0]   buf_addr,
  input  logic [DATA_W-1:0]   buf_wdata,
  input  logic                start,
  input  logic                repeat_en,
  input  logic [MEM_AW:0]     frame_len,
  frame_tx_master_if.master   wb,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         frame_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_LEN, S_SEND, S_POLL, S_GAP} state_t;
  // PH_REST is the mandatory cyc=0 cycle between two bus transactions.
  typedef enum logic [1:0] {PH_REQ, PH_ACK, PH_REST} phase_t;

  localparam logic [MEM_AW:0] MAX_LEN = {1'b1, {MEM_AW{1'b0}}};
  localparam logic [MEM_AW:0] ONE_LEN = {{MEM_AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [2**MEM_AW];

  state_t            state_r, state_n;
  phase_t            phase_r, phase_n;
  logic [MEM_AW:0]   ptr_r, ptr_n;
  logic [MEM_AW:0]   len_r, len_n;
  logic [15:0]       cnt_r, cnt_n;
  logic [15:0]       frame_cnt_r, frame_cnt_n;
  logic              busy_r, busy_n;
  logic              done_r, done_n;
  logic              err_r, err_n;
  logic              cyc_r, cyc_n;
  logic              stb_r, stb_n;
  logic              we_r, we_n;
  logic [1:0]        addr_r, addr_n;
  logic [DATA_W-1:0] data_r, data_n;
  logic              issue_s;
  logic              last_s;
  logic              len_ok_s;

  assign last_s   = (ptr_r == (len_r - ONE_LEN));
  assign len_ok_s = (frame_len != {(MEM_AW+1){1'b0}}) && (frame_len <= MAX_LEN);

  // Payload buffer: host writes are only taken while no frame is in flight.
  always_ff @(posedge clk) begin
    if (buf_we && !busy_r) begin
      mem[buf_addr] <= buf_wdata;
    end
  end

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    state_n     = state_r;
    phase_n     = phase_r;
    ptr_n       = ptr_r;
    len_n       = len_r;
    cnt_n       = cnt_r;
    frame_cnt_n = frame_cnt_r;
    cyc_n       = cyc_r;
    stb_n       = stb_r;
    we_n        = we_r;
    addr_n      = addr_r;
    data_n      = data_r;
    done_n      = 1'b0;
    err_n       = 1'b0;
    issue_s     = 1'b0;

    case (state_r)
      S_IDLE: begin
        cyc_n = 1'b0;
        stb_n = 1'b0;
        if (start) begin
          if (len_ok_s) begin
            state_n = S_DATA;
            ptr_n   = {(MEM_AW+1){1'b0}};
            len_n   = frame_len;
            issue_s = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GAP: begin
        // The first request of a repeated frame is issued on the exit edge
        // so the bus is idle for exactly GAP_CYC cycles.
        if (cnt_r == 16'(GAP_CYC - 1)) begin
          cnt_n = 16'd0;
          if (repeat_en) begin
            state_n = S_DATA;
            ptr_n   = {(MEM_AW+1){1'b0}};
            issue_s = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt_r + 16'd1;
        end
      end
      default: begin
        case (phase_r)
          PH_REQ: begin
            if (!wb.i_wb_stall) begin
              stb_n   = 1'b0;
              phase_n = PH_ACK;
              cnt_n   = 16'd0;
            end else begin
              stb_n = 1'b1;
            end
          end
          PH_ACK: begin
            if (wb.i_wb_ack) begin
              cyc_n   = 1'b0;
              phase_n = PH_REST;
              cnt_n   = 16'd0;
              case (state_r)
                S_DATA: begin
                  if (last_s) begin
                    state_n = S_LEN;
                  end else begin
                    ptr_n = ptr_r + ONE_LEN;
                  end
                end
                S_LEN:  state_n = S_SEND;
                S_SEND: state_n = S_POLL;
                S_POLL: begin
                  if (!wb.i_wb_data[0]) begin
                    state_n     = S_GAP;
                    done_n      = 1'b1;
                    frame_cnt_n = frame_cnt_r + 16'd1;
                  end else begin
                    state_n = S_POLL;
                  end
                end
                default: state_n = S_IDLE;
              endcase
            end else if (cnt_r == 16'(ACK_TIMEOUT - 1)) begin
              cyc_n   = 1'b0;
              stb_n   = 1'b0;
              phase_n = PH_REQ;
              state_n = S_IDLE;
              cnt_n   = 16'd0;
              err_n   = 1'b1;
            end else begin
              cnt_n = cnt_r + 16'd1;
            end
          end
          PH_REST: issue_s = 1'b1;
          default: begin
            cyc_n   = 1'b0;
            stb_n   = 1'b0;
            phase_n = PH_REQ;
            state_n = S_IDLE;
          end
        endcase
      end
    endcase

    // Launch the request belonging to the state being entered.
    if (issue_s) begin
      cyc_n   = 1'b1;
      stb_n   = 1'b1;
      phase_n = PH_REQ;
      case (state_n)
        S_DATA: begin
          we_n   = 1'b1;
          addr_n = 2'd0;
          data_n = mem[ptr_n[MEM_AW-1:0]];
        end
        S_LEN: begin
          we_n   = 1'b1;
          addr_n = 2'd1;
          data_n = DATA_W'(32'(len_r) + 32'(CRC_BYTES) - 32'd1);
        end
        S_SEND: begin
          we_n   = 1'b1;
          addr_n = 2'd3;
          data_n = {DATA_W{1'b0}};
        end
        S_POLL: begin
          we_n   = 1'b0;
          addr_n = 2'd2;
          data_n = {DATA_W{1'b0}};
        end
        default: begin
          cyc_n = 1'b0;
          stb_n = 1'b0;
        end
      endcase
    end else begin
      issue_s = 1'b0;
    end

    busy_n = (state_n != S_IDLE);
  end

  // State, counters and registered bus/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      phase_r     <= PH_REQ;
      ptr_r       <= {(MEM_AW+1){1'b0}};
      len_r       <= {(MEM_AW+1){1'b0}};
      cnt_r       <= 16'd0;
      frame_cnt_r <= 16'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      addr_r      <= 2'd0;
      data_r      <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_n;
      phase_r     <= phase_n;
      ptr_r       <= ptr_n;
      len_r       <= len_n;
      cnt_r       <= cnt_n;
      frame_cnt_r <= frame_cnt_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      err_r       <= err_n;
      cyc_r       <= cyc_n;
      stb_r       <= stb_n;
      we_r        <= we_n;
      addr_r      <= addr_n;
      data_r      <= data_n;
    end
  end

  assign wb.o_wb_cyc  = cyc_r;
  assign wb.o_wb_stb  = stb_r;
  assign wb.o_wb_we   = we_r;
  assign wb.o_wb_addr = addr_r;
  assign wb.o_wb_data = data_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err          = err_r;
  assign frame_cnt    = frame_cnt_r;

endmodule

// File: tb/tb_frame_tx_master.sv
// Bench for frame_tx_master: Wishbone slave model with stall/ack/status
// control and a scoreboard of expected bus transactions.
module tb_frame_tx_master;

  logic       clk;
  logic       rst_n;
  logic       buf_we;
  logic [7:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       start;
  logic       repeat_en;
  logic [8:0] frame_len;
  logic       busy;
  logic       done;
  logic       err;
  logic [15:0] frame_cnt;

  frame_tx_master_if #(.DATA_W(8)) wb ();

  frame_tx_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .start     (start),
    .repeat_en (repeat_en),
    .frame_len (frame_len),
    .wb        (wb),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  poll_q[$];
  logic [7:0]  model_mem [256];

  int   cyc_no     = 0;
  int   acc_cycle  = 0;
  int   req_num    = 0;
  int   stall_idx  = -1;
  int   stall_left = 0;
  int   stall_cnt  = 0;
  int   poll_reads = 0;
  int   cyc_seen   = 0;
  int   exp_frames = 0;
  logic [31:0] stall_exp = 32'd0;
  logic pend      = 1'b0;
  logic pend_read = 1'b0;
  logic noack     = 1'b0;
  logic stray_ack = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurements.
  always @(posedge clk) cyc_no <= cyc_no + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic we, input logic [1:0] a, input logic [7:0] d);
    return {21'd0, we, a, d};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Slave model: stall/accept requests, ack one cycle after acceptance.
  initial begin
    wb.i_wb_ack   = 1'b0;
    wb.i_wb_stall = 1'b0;
    wb.i_wb_data  = 8'h00;
    forever begin
      step();
      wb.i_wb_ack  = stray_ack;
      wb.i_wb_data = 8'h00;
      if (pend) begin
        if (!noack) begin
          wb.i_wb_ack = 1'b1;
          if (pend_read) begin
            if (poll_q.size() > 0) wb.i_wb_data = poll_q.pop_front();
            else wb.i_wb_data = 8'h00;
          end
        end
        pend = 1'b0;
      end
      wb.i_wb_stall = 1'b0;
      if (rst_n && wb.o_wb_cyc) cyc_seen++;
      if (rst_n && wb.o_wb_cyc && wb.o_wb_stb) begin
        if (req_num == stall_idx && stall_left > 0) begin
          wb.i_wb_stall = 1'b1;
          stall_left--;
          stall_cnt++;
          check("stall_hold", pack(wb.o_wb_we, wb.o_wb_addr, wb.o_wb_data), stall_exp);
        end else begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_req", pack(wb.o_wb_we, wb.o_wb_addr, wb.o_wb_data), 32'hFFFF_FFFF);
          end else begin
            check("sb_req", pack(wb.o_wb_we, wb.o_wb_addr, wb.o_wb_data), exp_q.pop_front());
          end
          if (!wb.o_wb_we && wb.o_wb_addr == 2'd2) poll_reads++;
          pend      = 1'b1;
          pend_read = !wb.o_wb_we;
          acc_cycle = cyc_no;
          req_num++;
        end
      end
    end
  end

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      buf_we    = 1'b1;
      buf_addr  = 8'(i);
      buf_wdata = base + 8'(i);
      model_mem[i] = base + 8'(i);
      step();
    end
    buf_we = 1'b0;
  endtask

  task automatic push_frame(input int len, input int npoll);
    for (int i = 0; i < len; i++) exp_q.push_back(pack(1'b1, 2'd0, model_mem[i]));
    exp_q.push_back(pack(1'b1, 2'd1, 8'(len + 3)));
    exp_q.push_back(pack(1'b1, 2'd3, 8'h00));
    for (int i = 0; i < npoll; i++) exp_q.push_back(pack(1'b0, 2'd2, 8'h00));
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      step();
      if (done) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  // Gap ending in IDLE: busy stays high exactly GAP_CYC cycles from done.
  task automatic gap_busy(input string tag);
    int n = 1;
    int viol = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (wb.o_wb_cyc) viol++;
      if (!busy) break;
      n++;
    end
    check({tag, "_len"}, 32'(n), 32'd100);
    check({tag, "_idle"}, 32'(viol), 32'd0);
  endtask

  // Gap ending in a repeat: cyc low exactly GAP_CYC cycles from done.
  task automatic gap_cyc(input string tag);
    int n = 1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (wb.o_wb_cyc) break;
      n++;
    end
    check(tag, 32'(n), 32'd100);
  endtask

  initial begin
    logic found;
    int base;
    rst_n = 1'b0; buf_we = 1'b0; buf_addr = 8'd0; buf_wdata = 8'd0;
    start = 1'b0; repeat_en = 1'b0; frame_len = 9'd0;
    step(); step();
    rst_n = 1'b1;
    step();
    check("rst_cyc", 32'(wb.o_wb_cyc), 32'd0);
    check("rst_stb", 32'(wb.o_wb_stb), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_fcnt", 32'(frame_cnt), 32'd0);

    // Basic frame; start and buffer write while busy are ignored.
    load(4, 8'h10);
    frame_len = 9'd4; push_frame(4, 1); poll_q.push_back(8'h00); poll_reads = 0;
    pulse_start();
    step();
    start = 1'b1; buf_we = 1'b1; buf_addr = 8'd0; buf_wdata = 8'hEE;
    step();
    start = 1'b0; buf_we = 1'b0;
    wait_done("t1_done");
    exp_frames++;
    check("t1_fcnt", 32'(frame_cnt), 32'(exp_frames));
    check("t1_polls", 32'(poll_reads), 32'd1);
    gap_busy("t1_gap");
    check("t1_sb_drain", 32'(exp_q.size()), 32'd0);

    // Three-cycle stall on the second data write.
    stall_idx = 1; stall_left = 3; stall_cnt = 0; req_num = 0;
    stall_exp = pack(1'b1, 2'd0, 8'h11);
    push_frame(4, 1); poll_q.push_back(8'h00);
    pulse_start();
    wait_done("t2_done");
    exp_frames++;
    check("t2_fcnt", 32'(frame_cnt), 32'(exp_frames));
    check("t2_stalls", 32'(stall_cnt), 32'd3);
    gap_busy("t2_gap");
    check("t2_sb_drain", 32'(exp_q.size()), 32'd0);
    stall_idx = -1;

    // Slave busy twice then ready: three status reads.
    frame_len = 9'd2; push_frame(2, 3); poll_reads = 0;
    poll_q.push_back(8'h01); poll_q.push_back(8'h01); poll_q.push_back(8'h00);
    pulse_start();
    wait_done("t3_done");
    exp_frames++;
    check("t3_polls", 32'(poll_reads), 32'd3);
    check("t3_fcnt", 32'(frame_cnt), 32'(exp_frames));
    gap_busy("t3_gap");
    check("t3_sb_drain", 32'(exp_q.size()), 32'd0);

    // Missing ack: timeout after 255 wait cycles.
    noack = 1'b1; frame_len = 9'd4;
    exp_q.push_back(pack(1'b1, 2'd0, model_mem[0]));
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      step();
      if (err) found = 1'b1;
    end
    check("t4_err_seen", 32'(found), 32'd1);
    check("t4_err_lat", 32'(cyc_no - acc_cycle), 32'd256);
    check("t4_cyc", 32'(wb.o_wb_cyc), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_fcnt", 32'(frame_cnt), 32'(exp_frames));
    step();
    check("t4_err_pulse", 32'(err), 32'd0);
    noack = 1'b0;
    base = cyc_seen;
    stray_ack = 1'b1;
    step(); step(); step();
    stray_ack = 1'b0;
    step();
    check("t4_stray_ack", 32'(cyc_seen - base), 32'd0);
    check("t4_stray_busy", 32'(busy), 32'd0);
    check("t4_sb_drain", 32'(exp_q.size()), 32'd0);

    // Repeat mode with one-byte frames.
    frame_len = 9'd1; repeat_en = 1'b1;
    push_frame(1, 1); push_frame(1, 1);
    poll_q.push_back(8'h00); poll_q.push_back(8'h00);
    pulse_start();
    wait_done("t5_done1");
    exp_frames++;
    check("t5_fcnt1", 32'(frame_cnt), 32'(exp_frames));
    gap_cyc("t5_gap1");
    repeat_en = 1'b0;
    wait_done("t5_done2");
    exp_frames++;
    check("t5_fcnt2", 32'(frame_cnt), 32'(exp_frames));
    gap_busy("t5_gap2");
    check("t5_sb_drain", 32'(exp_q.size()), 32'd0);

    // Invalid lengths: error pulse only.
    base = req_num;
    frame_len = 9'd0;
    pulse_start();
    check("t5_len0_err", 32'(err), 32'd1);
    check("t5_len0_busy", 32'(busy), 32'd0);
    step();
    check("t5_len0_errpulse", 32'(err), 32'd0);
    frame_len = 9'd257;
    pulse_start();
    check("t5_len257_err", 32'(err), 32'd1);
    step(); step(); step(); step();
    check("t5_no_bus", 32'(req_num - base), 32'd0);
    check("t5_fcnt_keep", 32'(frame_cnt), 32'(exp_frames));

    // Reset during a stalled write.
    stall_idx = 0; stall_left = 1000; req_num = 0;
    stall_exp = pack(1'b1, 2'd0, model_mem[0]);
    frame_len = 9'd4;
    pulse_start();
    step(); step(); step();
    rst_n = 1'b0;
    #1;
    check("t6_rst_cyc", 32'(wb.o_wb_cyc), 32'd0);
    check("t6_rst_stb", 32'(wb.o_wb_stb), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_fcnt", 32'(frame_cnt), 32'd0);
    stall_left = 0; stall_idx = -1; pend = 1'b0;
    step(); step();
    rst_n = 1'b1;
    base = cyc_seen;
    for (int i = 0; i < 20; i++) step();
    check("t6_quiet", 32'(cyc_seen - base), 32'd0);
    exp_frames = 0;
    frame_len = 9'd1; push_frame(1, 1); poll_q.push_back(8'h00);
    pulse_start();
    wait_done("t6_done");
    exp_frames++;
    check("t6_fcnt", 32'(frame_cnt), 32'(exp_frames));
    gap_busy("t6_gap");
    check("t6_sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_tx_master.md
FRAME_TX_MASTER -- requirements
Module: frame_tx_master

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, bus/buffer data width; MEM_AW, 8, buffer address width (depth 2^MEM_AW); CRC_BYTES, 4, bytes the MAC appends; GAP_CYC, 100, idle cycles between frames; ACK_TIMEOUT, 255, max cycles waiting for ack.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 buf_we  in  1  buffer write strobe.
REQ-005 buf_addr  in  MEM_AW  buffer write address.
REQ-006 buf_wdata  in  DATA_W  buffer write data.
REQ-007 start  in  1  one-cycle request to send a frame.
REQ-008 repeat_en  in  1  when high, frames re-send automatically after the gap.
REQ-009 frame_len  in  MEM_AW+1  payload byte count, valid range 1..2^MEM_AW.
REQ-010 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone pipelined master controls.
REQ-011 o_wb_addr  out  2  slave register: 0 data, 1 length, 2 status, 3 send.
REQ-012 o_wb_data  out  DATA_W  write data.
REQ-013 i_wb_ack, i_wb_stall  in  1 each  slave ack/stall; i_wb_data  in  DATA_W  read data (status bit 0 = slave busy).
REQ-014 busy  out  1  high from accepted start until IDLE re-entered.
REQ-015 done  out  1  one-cycle pulse per completed frame.
REQ-016 err  out  1  one-cycle pulse on timeout or invalid length.
REQ-017 frame_cnt  out  16  completed-frame count, wraps 0xFFFF->0.

Function
REQ-018 Block SHALL hold an internal 2^MEM_AW x DATA_W buffer written only by buf_we when busy=0; writes while busy=1 SHALL be ignored.
REQ-019 States SHALL be IDLE, DATA, LEN, SEND, POLL, GAP; each bus state has sub-phases REQ and ACK.
REQ-020 IDLE: start=1 with busy=0 SHALL latch frame_len and go to DATA with ptr=0; start while busy=1 SHALL be ignored.
REQ-021 frame_len=0 or >2^MEM_AW at start SHALL pulse err next cycle, stay IDLE, issue no bus cycle.
REQ-022 REQ phase: cyc=stb=1 with addr/we/data valid; all held stable while i_wb_stall=1; request accepted on the first cycle stb=1 and stall=0.
REQ-023 Cycle after acceptance: stb=0, cyc=1 until i_wb_ack; ack cycle ends the transaction; cyc=0 for at least one cycle between transactions.
REQ-024 ACK phase counts cycles; reaching ACK_TIMEOUT without ack SHALL drop cyc, pulse err, return to IDLE (busy=0), frame_cnt unchanged.
REQ-025 DATA: one write per byte, addr 0, data buffer[ptr], ptr 0..frame_len-1 in order; after last ack go to LEN.
REQ-026 LEN: write addr 1, data (frame_len+CRC_BYTES-1) truncated to DATA_W bits; then SEND.
REQ-027 SEND: write addr 3, data 0; then POLL.
REQ-028 POLL: read (we=0) addr 2; on ack, i_wb_data[0]=1 repeats the read, 0 goes to GAP; each poll read individually subject to REQ-024.
REQ-029 Entering GAP SHALL pulse done and increment frame_cnt in the same cycle.
REQ-030 GAP: bus idle for exactly GAP_CYC cycles; then DATA (ptr=0, same latched length) if repeat_en=1 else IDLE.
REQ-031 repeat_en SHALL be sampled only at GAP exit; start during GAP ignored.
REQ-032 Acks arriving while cyc=0 SHALL be ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE and cyc, stb, we, addr, data, busy, done, err, frame_cnt, ptr and counters to 0; buffer contents are not reset.
REQ-034 Reset mid-transaction SHALL drop cyc asynchronously; first post-reset bus cycle occurs only after a new start.

Verification
REQ-035 Load bytes 0x10..0x13, frame_len=4, no stall, ack next cycle -> writes addr0 0x10,0x11,0x12,0x13; addr1 0x07; addr3 0x00; poll addr2 returns 0 -> done, frame_cnt=1, 100 idle cycles, busy=0.
REQ-036 Stall held 3 cycles on second data write -> addr/data 0x11 held stable 3 cycles, single ack, sequence otherwise unchanged.
REQ-037 Status returns busy twice then 0 -> exactly three addr2 reads before GAP.
REQ-038 No ack after a data write -> err pulse at cycle 255 of wait, cyc=0, busy=0, frame_cnt unchanged.
REQ-039 repeat_en=1, frame_len=1 -> identical frames back-to-back separated by 100 idle cycles, frame_cnt increments each; start=1 with frame_len=0 -> err only.
REQ-040 rst_n low during a stalled write -> cyc=stb=0 immediately, no bus activity until next start.
